// File: rtl/conv_mac_pkg.sv
// Shared width helpers and the fixed-point shift/saturate function for the
// convolution MAC engine.
package conv_mac_pkg;

    // Working width for sat_shift; comfortably wider than any accumulator.
    localparam int SAT_WIDTH = 128;
    localparam logic signed [SAT_WIDTH-1:0] SAT_ONE = 1;

    typedef struct packed {
        logic [SAT_WIDTH-1:0] value;
        logic                 overflow;
    } sat_result_t;

    function automatic int calc_taps(input int kernel_size);
        return kernel_size * kernel_size;
    endfunction

    // A single tap needs no adder level at all.
    function automatic int calc_tree_depth(input int taps);
        return (taps <= 1) ? 0 : $clog2(taps);
    endfunction

    function automatic int calc_prod_width(input int data_width);
        return 2 * data_width;
    endfunction

    function automatic int calc_sum_width(input int data_width, input int taps);
        return calc_prod_width(data_width) + calc_tree_depth(taps);
    endfunction

    // 16 guard bits let long multi-beat frames accumulate without wrapping.
    function automatic int calc_acc_width(input int data_width, input int taps);
        return calc_sum_width(data_width, taps) + 16;
    endfunction

    // Arithmetic right shift (floor), then clamp to a signed out_width range.
    function automatic sat_result_t sat_shift(input logic signed [SAT_WIDTH-1:0] value,
                                              input int shift, input int out_width);
        logic signed [SAT_WIDTH-1:0] shifted;
        logic signed [SAT_WIDTH-1:0] limit;
        logic signed [SAT_WIDTH-1:0] hi;
        logic signed [SAT_WIDTH-1:0] lo;
        sat_result_t r;
        shifted    = value >>> shift;
        limit      = SAT_ONE <<< (out_width - 1);
        hi         = limit - SAT_ONE;
        lo         = -limit;
        r.value    = shifted;
        r.overflow = 1'b0;
        if (shifted > hi) begin
            r.value    = hi;
            r.overflow = 1'b1;
        end else if (shifted < lo) begin
            r.value    = lo;
            r.overflow = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/conv_adder_tree.sv
// Pipelined pairwise adder tree: one register per level, leaves padded with
// zero up to a power of two so an odd node always pairs with zero.
module conv_adder_tree
    import conv_mac_pkg::*;
#(
    parameter int  TAPS      = 9,
    parameter int  IN_WIDTH  = 16,
    localparam int DEPTH     = calc_tree_depth(TAPS),
    localparam int OUT_WIDTH = IN_WIDTH + DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [TAPS*IN_WIDTH-1:0]    in_data,
    output logic signed [OUT_WIDTH-1:0] sum
);

    localparam int PADDED   = 1 << DEPTH;
    localparam int LVL_BITS = PADDED * OUT_WIDTH;

    logic [LVL_BITS-1:0] lvl0;

    // Sign-extend each leaf to the full tree width; padding leaves are zero.
    always_comb begin
        lvl0 = '0;
        for (int t = 0; t < TAPS; t++) begin
            lvl0[t*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'($signed(in_data[t*IN_WIDTH +: IN_WIDTH]));
        end
    end

    generate
        if (DEPTH == 0) begin : g_pass
            assign sum = lvl0;
        end else begin : g_tree
            logic [DEPTH*LVL_BITS-1:0]     tree_q;
            logic [(DEPTH+1)*LVL_BITS-1:0] all_lvls;
            logic                          unused_pad;

            // Level l of the tree lives at slice l of all_lvls (level 0 = leaves).
            assign all_lvls   = {tree_q, lvl0};
            assign unused_pad = ^all_lvls;

            // Each level adds adjacent pairs of the level below; holds when en is low.
            always_ff @(posedge clk) begin
                if (rst) begin
                    tree_q <= '0;
                end else if (en) begin
                    for (int l = 0; l < DEPTH; l++) begin
                        for (int i = 0; i < PADDED; i++) begin
                            if (i < (PADDED >> (l + 1))) begin
                                tree_q[(l*PADDED+i)*OUT_WIDTH +: OUT_WIDTH] <=
                                    all_lvls[(l*PADDED+2*i)*OUT_WIDTH +: OUT_WIDTH] +
                                    all_lvls[(l*PADDED+2*i+1)*OUT_WIDTH +: OUT_WIDTH];
                            end else begin
                                tree_q[(l*PADDED+i)*OUT_WIDTH +: OUT_WIDTH] <= '0;
                            end
                        end
                    end
                end
            end

            assign sum = tree_q[(DEPTH-1)*LVL_BITS +: OUT_WIDTH];
        end
    endgenerate

endmodule

// File: rtl/conv_mac_engine.sv
// Multi-channel convolution MAC: registered products, pipelined adder tree,
// framed accumulation, then shift/saturate into a backpressured output register.
//
// Handshake: an input beat transfers on in_valid && in_ready; a result transfers
// on out_valid && out_ready. A held result (out_valid && !out_ready) freezes the
// whole pipeline, so in_ready is low exactly then (and during reset).
module conv_mac_engine
    import conv_mac_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int KERNEL_SIZE = 3,
    parameter int CHANNELS    = 1,
    parameter int OUT_WIDTH   = 32,
    parameter int SHIFT       = 0
) (
    input  logic                                                     Clk,
    input  logic                                                     Rst,
    input  logic [CHANNELS*calc_taps(KERNEL_SIZE)*DATA_WIDTH-1:0]    multiplier_input,
    input  logic [CHANNELS*calc_taps(KERNEL_SIZE)*DATA_WIDTH-1:0]    multiplicand_input,
    input  logic                                                     in_valid,
    input  logic                                                     in_first,
    input  logic                                                     in_last,
    output logic                                                     in_ready,
    output logic [CHANNELS*OUT_WIDTH-1:0]                            out_sum,
    output logic [CHANNELS-1:0]                                      out_overflow,
    output logic                                                     out_valid,
    input  logic                                                     out_ready
);

    localparam int TAPS       = calc_taps(KERNEL_SIZE);
    localparam int TREE_DEPTH = calc_tree_depth(TAPS);
    localparam int PROD_WIDTH = calc_prod_width(DATA_WIDTH);
    localparam int SUM_WIDTH  = calc_sum_width(DATA_WIDTH, TAPS);
    localparam int ACC_WIDTH  = calc_acc_width(DATA_WIDTH, TAPS);

    logic                stall;
    logic                en;
    logic                fire;
    logic                out_valid_q;
    logic [TREE_DEPTH:0] v_q;
    logic [TREE_DEPTH:0] f_q;
    logic [TREE_DEPTH:0] l_q;
    logic                tree_v;
    logic                tree_first;
    logic                tree_last;

    assign stall      = out_valid_q && !out_ready;
    assign en         = !stall;
    assign in_ready   = !stall && !Rst;
    assign fire       = in_valid && in_ready;
    assign out_valid  = out_valid_q;
    assign tree_v     = v_q[TREE_DEPTH];
    assign tree_first = f_q[TREE_DEPTH];
    assign tree_last  = l_q[TREE_DEPTH];

    // Beat valid/first/last ride alongside the data: index 0 = product stage.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            v_q <= '0;
            f_q <= '0;
            l_q <= '0;
        end else if (en) begin
            v_q[0] <= fire;
            f_q[0] <= fire && in_first;
            l_q[0] <= fire && in_last;
            for (int i = 1; i <= TREE_DEPTH; i++) begin
                v_q[i] <= v_q[i-1];
                f_q[i] <= f_q[i-1];
                l_q[i] <= l_q[i-1];
            end
        end
    end

    // A result is presented only for beats that close a frame.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            out_valid_q <= 1'b0;
        end else if (en) begin
            out_valid_q <= tree_v && tree_last;
        end
    end

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
            logic [TAPS*DATA_WIDTH-1:0]  a_ch;
            logic [TAPS*DATA_WIDTH-1:0]  b_ch;
            logic [TAPS*PROD_WIDTH-1:0]  prod_q;
            logic signed [SUM_WIDTH-1:0] tree_sum;
            logic signed [ACC_WIDTH-1:0] acc_q;
            logic signed [ACC_WIDTH-1:0] acc_base;
            logic signed [ACC_WIDTH-1:0] acc_new;
            logic                        sticky_q;
            logic                        sticky_new;
            sat_result_t                 sat_r;
            logic [OUT_WIDTH-1:0]        sum_q;
            logic                        ovf_q;
            logic                        unused_sat_hi;

            assign a_ch = multiplier_input[c*TAPS*DATA_WIDTH +: TAPS*DATA_WIDTH];
            assign b_ch = multiplicand_input[c*TAPS*DATA_WIDTH +: TAPS*DATA_WIDTH];

            // Full-precision signed products, one register per tap.
            always_ff @(posedge Clk) begin
                if (Rst) begin
                    prod_q <= '0;
                end else if (en) begin
                    for (int t = 0; t < TAPS; t++) begin
                        prod_q[t*PROD_WIDTH +: PROD_WIDTH] <=
                            PROD_WIDTH'($signed(a_ch[t*DATA_WIDTH +: DATA_WIDTH])) *
                            PROD_WIDTH'($signed(b_ch[t*DATA_WIDTH +: DATA_WIDTH]));
                    end
                end
            end

            conv_adder_tree #(
                .TAPS     (TAPS),
                .IN_WIDTH (PROD_WIDTH)
            ) u_tree (
                .clk     (Clk),
                .rst     (Rst),
                .en      (en),
                .in_data (prod_q),
                .sum     (tree_sum)
            );

            // Next accumulator value and its scaled/saturated view; first restarts the frame.
            always_comb begin
                acc_base   = tree_first ? '0 : acc_q;
                acc_new    = acc_base + ACC_WIDTH'(tree_sum);
                sat_r      = sat_shift(SAT_WIDTH'(acc_new), SHIFT, OUT_WIDTH);
                sticky_new = (tree_first ? 1'b0 : sticky_q) | sat_r.overflow;
            end

            assign unused_sat_hi = ^sat_r.value[SAT_WIDTH-1:OUT_WIDTH];

            // Accumulate every valid beat; load the output register on frame end.
            always_ff @(posedge Clk) begin
                if (Rst) begin
                    acc_q    <= '0;
                    sticky_q <= 1'b0;
                    sum_q    <= '0;
                    ovf_q    <= 1'b0;
                end else if (en && tree_v) begin
                    acc_q    <= acc_new;
                    sticky_q <= sticky_new;
                    if (tree_last) begin
                        sum_q <= sat_r.value[OUT_WIDTH-1:0];
                        ovf_q <= sticky_new;
                    end
                end
            end

            assign out_sum[c*OUT_WIDTH +: OUT_WIDTH] = sum_q;
            assign out_overflow[c]                   = ovf_q;
        end
    endgenerate

endmodule

// File: tb/tb_conv_mac_engine.sv
// Directed bench for conv_mac_engine (8-bit data, 3x3 kernel, 2 channels,
// 16-bit outputs). A second instance is built with SHIFT=2.
module tb_conv_mac_engine;

    localparam int DW   = 8;
    localparam int KS   = 3;
    localparam int CH   = 2;
    localparam int OW   = 16;
    localparam int TAPS = KS * KS;
    localparam int FLAT = CH * TAPS * DW;

    logic Clk = 1'b0;
    logic Rst;

    logic [FLAT-1:0]  mul_a;
    logic [FLAT-1:0]  mul_b;
    logic             in_valid;
    logic             in_first;
    logic             in_last;
    logic             in_ready;
    logic [CH*OW-1:0] out_sum;
    logic [CH-1:0]    out_overflow;
    logic             out_valid;
    logic             out_ready;

    logic [FLAT-1:0]  mul_a2;
    logic [FLAT-1:0]  mul_b2;
    logic             in_valid2;
    logic             in_first2;
    logic             in_last2;
    logic             in_ready2;
    logic [CH*OW-1:0] out_sum2;
    logic [CH-1:0]    out_overflow2;
    logic             out_valid2;
    logic             out_ready2;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    // Clock
    always #5 Clk = ~Clk;

    conv_mac_engine #(
        .DATA_WIDTH (DW), .KERNEL_SIZE (KS), .CHANNELS (CH), .OUT_WIDTH (OW), .SHIFT (0)
    ) dut (
        .Clk (Clk), .Rst (Rst),
        .multiplier_input (mul_a), .multiplicand_input (mul_b),
        .in_valid (in_valid), .in_first (in_first), .in_last (in_last), .in_ready (in_ready),
        .out_sum (out_sum), .out_overflow (out_overflow),
        .out_valid (out_valid), .out_ready (out_ready)
    );

    conv_mac_engine #(
        .DATA_WIDTH (DW), .KERNEL_SIZE (KS), .CHANNELS (CH), .OUT_WIDTH (OW), .SHIFT (2)
    ) dut_shift (
        .Clk (Clk), .Rst (Rst),
        .multiplier_input (mul_a2), .multiplicand_input (mul_b2),
        .in_valid (in_valid2), .in_first (in_first2), .in_last (in_last2), .in_ready (in_ready2),
        .out_sum (out_sum2), .out_overflow (out_overflow2),
        .out_valid (out_valid2), .out_ready (out_ready2)
    );

    function automatic logic [15:0] s16(input int v);
        return v[15:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_taps();
        mul_a = '0;
        mul_b = '0;
    endtask

    task automatic set_tap(input int c, input int t, input int a, input int b);
        mul_a[(c*TAPS+t)*DW +: DW] = a[DW-1:0];
        mul_b[(c*TAPS+t)*DW +: DW] = b[DW-1:0];
    endtask

    task automatic set_all(input int c, input int a, input int b);
        for (int t = 0; t < TAPS; t++) set_tap(c, t, a, b);
    endtask

    // Present one beat on the main DUT; returns one cycle after acceptance (+1).
    task automatic send_beat(input bit first, input bit last);
        bit taken = 1'b0;
        in_first = first;
        in_last  = last;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !taken; i++) begin
            #1;
            taken = in_ready;
            @(posedge Clk);
            #1;
        end
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        check("send_accept", 32'(taken), 32'd1);
    endtask

    // Count rising edges until out_valid (which=0: main, 1: shift build); -1 on timeout.
    task automatic wait_valid(input bit which, output int lat);
        lat = 0;
        while (!(which ? out_valid2 : out_valid) && lat < 20) begin
            @(posedge Clk);
            #1;
            lat++;
        end
        if (lat >= 20) lat = -1;
    endtask

    initial begin
        int lat;
        int sent;
        int got;
        bit prev_stall;
        bit seen;
        logic [31:0] prev_sum;
        logic [31:0] e;

        Rst = 1'b1;
        clear_taps();
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        mul_a2 = '0; mul_b2 = '0;
        in_valid2 = 1'b0; in_first2 = 1'b0; in_last2 = 1'b0; out_ready2 = 1'b1;

        // Reset state
        repeat (2) @(posedge Clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", out_sum, 32'd0);
        check("rst_out_ovf", 32'(out_overflow), 32'd0);
        check("rst_in_ready_low", 32'(in_ready), 32'd0);
        Rst = 1'b0;
        #1;
        check("rst_in_ready_high", 32'(in_ready), 32'd1);

        // Single-beat frame: ch0 9*(1*2)=18, ch1 9*(3*-1)=-27
        clear_taps();
        set_all(0, 1, 2);
        set_all(1, 3, -1);
        send_beat(1'b1, 1'b1);
        wait_valid(1'b0, lat);
        check("single_latency", 32'(lat), 32'd5);
        check("single_ch0", 32'(out_sum[15:0]), 32'(s16(18)));
        check("single_ch1", 32'(out_sum[31:16]), 32'(s16(-27)));
        check("single_ovf", 32'(out_overflow), 32'd0);
        @(posedge Clk);
        #1;
        check("single_valid_drop", 32'(out_valid), 32'd0);

        // Three-beat frame: ch0 10+20-5=25, ch1 1+1+1=3
        clear_taps(); set_tap(0, 0, 2, 3); set_tap(0, 1, 4, 1); set_tap(1, 0, 1, 1);
        send_beat(1'b1, 1'b0);
        clear_taps(); set_tap(0, 0, 5, 4); set_tap(1, 0, 1, 1);
        send_beat(1'b0, 1'b0);
        clear_taps(); set_tap(0, 0, -5, 1); set_tap(1, 0, 1, 1);
        send_beat(1'b0, 1'b1);
        wait_valid(1'b0, lat);
        check("frame_latency", 32'(lat), 32'd5);
        check("frame_ch0", 32'(out_sum[15:0]), 32'(s16(25)));
        check("frame_ch1", 32'(out_sum[31:16]), 32'(s16(3)));
        check("frame_ovf", 32'(out_overflow), 32'd0);
        // New first beat discards the old accumulation: ch0 4, ch1 -4
        clear_taps(); set_tap(0, 0, 2, 2); set_tap(1, 0, -2, 2);
        send_beat(1'b1, 1'b1);
        wait_valid(1'b0, lat);
        check("restart_ch0", 32'(out_sum[15:0]), 32'(s16(4)));
        check("restart_ch1", 32'(out_sum[31:16]), 32'(s16(-4)));

        // Saturation: ch0 145161 -> 32767, ch1 -146304 -> -32768
        clear_taps(); set_all(0, 127, 127); set_all(1, 127, -128);
        send_beat(1'b1, 1'b1);
        wait_valid(1'b0, lat);
        check("sat_ch0", 32'(out_sum[15:0]), 32'(s16(32767)));
        check("sat_ch1", 32'(out_sum[31:16]), 32'(s16(-32768)));
        check("sat_ovf", 32'(out_overflow), 32'd3);
        clear_taps(); set_tap(0, 0, 1, 1); set_tap(1, 0, -1, 1);
        send_beat(1'b1, 1'b1);
        wait_valid(1'b0, lat);
        check("sat_clear_ch0", 32'(out_sum[15:0]), 32'(s16(1)));
        check("sat_clear_ch1", 32'(out_sum[31:16]), 32'(s16(-1)));
        check("sat_clear_ovf", 32'(out_overflow), 32'd0);

        // Sticky overflow: 145161, then -145161, then +100 -> 100 with ch0 flag kept
        clear_taps(); set_all(0, 127, 127);
        send_beat(1'b1, 1'b0);
        clear_taps(); set_all(0, 127, -127);
        send_beat(1'b0, 1'b0);
        clear_taps(); set_tap(0, 0, 10, 10);
        send_beat(1'b0, 1'b1);
        wait_valid(1'b0, lat);
        check("sticky_ch0", 32'(out_sum[15:0]), 32'(s16(100)));
        check("sticky_ch1", 32'(out_sum[31:16]), 32'(s16(0)));
        check("sticky_ovf", 32'(out_overflow), 32'd1);
        @(posedge Clk);
        #1;
        check("sticky_valid_drop", 32'(out_valid), 32'd0);

        // Backpressure: 8 single-beat frames, out_ready low in cycles 7..11
        sent = 0;
        got = 0;
        prev_stall = 1'b0;
        prev_sum = '0;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            out_ready = !(cyc >= 7 && cyc <= 11);
            if (sent < 8) begin
                clear_taps();
                set_tap(0, 0, sent + 1, 3);
                set_tap(1, 0, sent + 1, -2);
                in_first = 1'b1;
                in_last  = 1'b1;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            check("bp_in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
            if (prev_stall) check("bp_hold", out_sum, prev_sum);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("bp_extra", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("bp_sum", out_sum, e);
                    check("bp_ovf", 32'(out_overflow), 32'd0);
                end
                got++;
            end
            prev_stall = out_valid && !out_ready;
            prev_sum   = out_sum;
            if (in_valid && in_ready) begin
                exp_q.push_back({s16(-2 * (sent + 1)), s16(3 * (sent + 1))});
                sent++;
            end
            @(posedge Clk);
            #1;
        end
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        check("bp_received", 32'(got), 32'd8);
        check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset with three beats in flight (and a beat offered during reset)
        clear_taps(); set_tap(0, 0, 7, 1);
        send_beat(1'b1, 1'b1);
        send_beat(1'b1, 1'b1);
        send_beat(1'b1, 1'b1);
        Rst = 1'b1;
        in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_sum", out_sum, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge Clk);
            #1;
            seen |= out_valid;
        end
        check("midrst_no_stale", 32'(seen), 32'd0);
        // Continue-from-acc beat (no first) proves the accumulator was cleared.
        clear_taps(); set_tap(0, 0, 5, 1);
        send_beat(1'b0, 1'b1);
        wait_valid(1'b0, lat);
        check("postrst_latency", 32'(lat), 32'd5);
        check("postrst_ch0", 32'(out_sum[15:0]), 32'(s16(5)));
        check("postrst_ch1", 32'(out_sum[31:16]), 32'(s16(0)));

        // SHIFT=2 build: 37 -> 9, -37 -> -10
        clear_taps(); set_tap(0, 0, 37, 1); set_tap(1, 0, -37, 1);
        mul_a2 = mul_a;
        mul_b2 = mul_b;
        in_first2 = 1'b1; in_last2 = 1'b1; in_valid2 = 1'b1;
        #1;
        check("shift_in_ready", 32'(in_ready2), 32'd1);
        @(posedge Clk);
        #1;
        in_valid2 = 1'b0; in_first2 = 1'b0; in_last2 = 1'b0;
        wait_valid(1'b1, lat);
        check("shift_latency", 32'(lat), 32'd5);
        check("shift_ch0", 32'(out_sum2[15:0]), 32'(s16(9)));
        check("shift_ch1", 32'(out_sum2[31:16]), 32'(s16(-10)));
        check("shift_ovf", 32'(out_overflow2), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
